// File: rtl/counter_monitor.sv
// rtl/counter_monitor.sv - hardware checker for an up/down counter's enable/direction/counter_out interface
//
// Watches the counter's controls and registered output every clock, predicts
// the next value and reports deviations with sticky and pulsed error outputs,
// a saturating mismatch count and the offending/predicted values.
//
// Build option: COUNTER_MONITOR_RESYNC_EN
//   defined   - FAULT lasts one cycle, the monitor re-locks onto counter_out
//               and keeps counting later mismatches.
//   undefined - FAULT is absorbing until rst=0 (first mismatch is retained).
//
// Ports:
//   clk          in   rising-edge clock shared with the monitored counter
//   rst          in   synchronous active-low monitor reset
//   ctr_rst      in   monitored counter's active-high reset (observed)
//   enable       in   monitored counter's enable (observed)
//   direction    in   monitored counter's direction, 1 = up (observed)
//   counter_out  in   monitored counter's registered output (observed)
//   err          out  sticky error flag
//   err_pulse    out  one-cycle pulse per detected mismatch
//   err_count    out  saturating mismatch count
//   bad_value    out  counter_out at the most recent mismatch
//   exp_value    out  predicted value at the most recent mismatch
//   wrap_count   out  number of predicted wrap events, modulo 256

module counter_monitor #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctr_rst,
    input  logic                 enable,
    input  logic                 direction,
    input  logic [WIDTH-1:0]     counter_out,
    output logic                 err,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     bad_value,
    output logic [WIDTH-1:0]     exp_value,
    output logic [7:0]           wrap_count
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     expected, expected_nxt;
    logic                 err_nxt, err_pulse_nxt;
    logic [ERR_CNT_W-1:0] err_count_nxt;
    logic [WIDTH-1:0]     bad_value_nxt, exp_value_nxt;
    logic [7:0]           wrap_count_nxt;

    logic [WIDTH-1:0]     predicted;
    logic                 wrap_evt;

    // Counter reset dominates enable, exactly as in the counter itself.
    always_comb begin
        predicted = counter_out;
        if (ctr_rst)
            predicted = '0;
        else if (enable && direction)
            predicted = counter_out + WIDTH'(1);
        else if (enable)
            predicted = counter_out - WIDTH'(1);
    end

    // The wrap is credited at the edge where it is predicted, not where the
    // wrapped value is later observed.
    assign wrap_evt = !ctr_rst && enable &&
                      (( direction && (counter_out == {WIDTH{1'b1}})) ||
                       (!direction && (counter_out == {WIDTH{1'b0}})));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= SYNC;
            expected   <= '0;
            err        <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            bad_value  <= '0;
            exp_value  <= '0;
            wrap_count <= '0;
        end else begin
            state      <= state_nxt;
            expected   <= expected_nxt;
            err        <= err_nxt;
            err_pulse  <= err_pulse_nxt;
            err_count  <= err_count_nxt;
            bad_value  <= bad_value_nxt;
            exp_value  <= exp_value_nxt;
            wrap_count <= wrap_count_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        expected_nxt   = expected;
        err_nxt        = err;
        err_pulse_nxt  = 1'b0;
        err_count_nxt  = err_count;
        bad_value_nxt  = bad_value;
        exp_value_nxt  = exp_value;
        wrap_count_nxt = wrap_count;

        case (state)
            SYNC: begin
                expected_nxt = predicted;
                state_nxt    = TRACK;
            end

            TRACK: begin
                if (counter_out == expected) begin
                    expected_nxt = predicted;
                    if (wrap_evt)
                        wrap_count_nxt = wrap_count + 8'd1;
                end else begin
                    err_nxt       = 1'b1;
                    err_pulse_nxt = 1'b1;
                    if (err_count != {ERR_CNT_W{1'b1}})
                        err_count_nxt = err_count + ERR_CNT_W'(1);
                    bad_value_nxt = counter_out;
                    exp_value_nxt = expected;
                    state_nxt     = FAULT;
                end
            end

            FAULT: begin
`ifdef COUNTER_MONITOR_RESYNC_EN
                // Re-lock on whatever the counter now shows; no compare here.
                expected_nxt = predicted;
                state_nxt    = TRACK;
`else
                state_nxt    = FAULT;
`endif
            end

            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

endmodule
